// File: rtl/vwiden_seq.sv
// vwiden_seq: two-beat sequencer feeding the vector ALU widening path (low half, then high half).
// Optional VWIDEN_SEQ_HALF_SKIP_EN drops BEAT1 when the upper-half byte enables are all zero.
module vwiden_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int BE_WIDTH   = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [SEW_WIDTH-1:0]  in_sew,
  input  logic [BE_WIDTH-1:0]   in_be,
  input  logic                  in_signed0,
  input  logic                  in_signed1,
  input  logic                  in_widen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec0,
  output logic [DATA_WIDTH-1:0] out_vec1,
  output logic [BE_WIDTH-1:0]   out_be,
  output logic [SEW_WIDTH-1:0]  out_sew,
  output logic                  out_turn,
  output logic                  out_last,
  output logic                  err_sew
);
  localparam int HW = DATA_WIDTH/2;
  localparam int HB = BE_WIDTH/2;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] vec0_q, vec0_d, vec1_q, vec1_d;
  logic [SEW_WIDTH-1:0] sew_q, sew_d, sew_w;
  logic [BE_WIDTH-1:0] be_q, be_d, be_w;
  logic s0_q, s0_d, s1_q, s1_d, widen_q, widen_d, err_q, err_d;
  logic illegal, two_beat, turn, accept;
  logic [HW-1:0] h0, h1;
  logic [HB-1:0] hbe;
  // Byte-granular sign/zero extension so one loop serves every legal element width.
  function automatic logic [DATA_WIDTH-1:0] widen_half(input logic [HW-1:0] h, input logic [SEW_WIDTH-1:0] sew, input logic sgn);
    int eb, k, o;
    widen_half = '0;
    eb = 1 << sew;
    for (int j = 0; j < BE_WIDTH; j++) begin
      k = j / (2*eb);
      o = j % (2*eb);
      widen_half[j*8 +: 8] = o < eb ? h[(k*eb+o)*8 +: 8] : {8{sgn & h[(k*eb+eb)*8-1]}};
    end
  endfunction
  assign illegal = widen_q && &sew_q;
`ifdef VWIDEN_SEQ_HALF_SKIP_EN
  assign two_beat = widen_q && !illegal && |be_q[BE_WIDTH-1:HB];
`else
  assign two_beat = widen_q && !illegal;
`endif
  assign turn = state_q == BEAT1;
  assign out_valid = state_q != IDLE;
  assign out_turn = turn;
  assign out_last = (state_q == BEAT0 && !two_beat) || turn;
  assign in_ready = !out_valid || (out_ready && out_last);
  assign accept = in_valid && in_ready;
  assign err_sew = err_q;
  assign h0 = turn ? vec0_q[DATA_WIDTH-1:HW] : vec0_q[HW-1:0];
  assign h1 = turn ? vec1_q[DATA_WIDTH-1:HW] : vec1_q[HW-1:0];
  assign hbe = turn ? be_q[BE_WIDTH-1:HB] : be_q[HB-1:0];
  assign sew_w = illegal ? '0 : sew_q;
  always_comb begin
    be_w = '0;
    for (int i = 0; i < HB; i++) be_w[2*i +: 2] = {2{hbe[i]}};
    out_vec0 = illegal ? '0 : widen_q ? widen_half(h0, sew_w, s0_q) : vec0_q;
    out_vec1 = illegal ? '0 : widen_q ? widen_half(h1, sew_w, s1_q) : vec1_q;
    out_be = illegal ? '0 : widen_q ? be_w : be_q;
    out_sew = illegal ? '0 : sew_q + SEW_WIDTH'(widen_q);
    state_d = state_q;
    if (!out_valid) state_d = accept ? BEAT0 : IDLE;
    else if (out_ready) state_d = (state_q == BEAT0 && two_beat) ? BEAT1 : accept ? BEAT0 : IDLE;
    vec0_d = accept ? in_vec0 : vec0_q;
    vec1_d = accept ? in_vec1 : vec1_q;
    sew_d = accept ? in_sew : sew_q;
    be_d = accept ? in_be : be_q;
    s0_d = accept ? in_signed0 : s0_q;
    s1_d = accept ? in_signed1 : s1_q;
    widen_d = accept ? in_widen : widen_q;
    err_d = accept && in_widen && &in_sew;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec0_q <= '0;
      vec1_q <= '0;
      sew_q <= '0;
      be_q <= '0;
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      widen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec0_q <= vec0_d;
      vec1_q <= vec1_d;
      sew_q <= sew_d;
      be_q <= be_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      widen_q <= widen_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_vwiden_seq.sv
// tb_vwiden_seq: directed table-driven checks of vwiden_seq plus stall, back-to-back, sew=3 and reset sequences.
module tb_vwiden_seq;
`ifdef VWIDEN_SEQ_HALF_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_signed0 = 1'b0, in_signed1 = 1'b0, in_widen = 1'b0;
  logic [63:0] in_vec0 = '0, in_vec1 = '0, out_vec0, out_vec1;
  logic [1:0] in_sew = '0, out_sew;
  logic [7:0] in_be = '0, out_be;
  logic out_valid, out_ready = 1'b0, out_turn, out_last, err_sew;
  int n_cmp = 0, n_fail = 0;
  string tag;
  typedef struct {
    logic [63:0] v0, v1;
    logic [1:0] sew;
    logic [7:0] be;
    logic s0, s1, w;
    int nb;
    logic [63:0] a0, a1, b0, b1;
    logic [7:0] abe, bbe;
    logic [1:0] esew;
  } vec_t;
  vec_t tbl[7];

  vwiden_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_be(in_be),
    .in_signed0(in_signed0), .in_signed1(in_signed1), .in_widen(in_widen),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec0(out_vec0), .out_vec1(out_vec1),
    .out_be(out_be), .out_sew(out_sew), .out_turn(out_turn), .out_last(out_last), .err_sew(err_sew)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h, want %h", tag, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_vec0 = v.v0; in_vec1 = v.v1; in_sew = v.sew; in_be = v.be;
    in_signed0 = v.s0; in_signed1 = v.s1; in_widen = v.w; in_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    drive(v);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < v.nb; b++) begin
      chk("valid", out_valid, 1);
      chk("vec0", out_vec0, b ? v.b0 : v.a0);
      chk("vec1", out_vec1, b ? v.b1 : v.a1);
      chk("be", out_be, b ? v.bbe : v.abe);
      chk("sew", out_sew, v.esew);
      chk("turn", out_turn, b);
      chk("last", out_last, b == v.nb - 1);
      chk("err", err_sew, b == 0 && v.w && v.sew == 2'd3);
      @(negedge clk);
    end
    chk("done", out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{64'h8081_8283_8485_8687, 64'h0102_0304_0506_0708, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 2,
               64'h0084_0085_0086_0087, 64'h0005_0006_0007_0008, 64'h0080_0081_0082_0083, 64'h0001_0002_0003_0004,
               8'hFF, 8'hFF, 2'd1};
    tbl[1] = '{64'h8081_8283_8485_8687, 64'h0102_0304_0506_0708, 2'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 2,
               64'hFF84_FF85_FF86_FF87, 64'h0005_0006_0007_0008, 64'hFF80_FF81_FF82_FF83, 64'h0001_0002_0003_0004,
               8'hFF, 8'hFF, 2'd1};
    tbl[2] = '{64'h1111_2222_3333_4444, 64'h8000_7FFF_1234_FFFE, 2'd1, 8'hF3, 1'b0, 1'b1, 1'b1, 2,
               64'h0000_3333_0000_4444, 64'h0000_1234_FFFF_FFFE, 64'h0000_1111_0000_2222, 64'hFFFF_8000_0000_7FFF,
               8'h0F, 8'hFF, 2'd2};
    tbl[3] = '{64'hDEAD_BEEF_8000_0001, 64'h0000_0000_0000_0007, 2'd2, 8'h0F, 1'b1, 1'b0, 1'b1, SKIP ? 1 : 2,
               64'hFFFF_FFFF_8000_0001, 64'h0000_0000_0000_0007, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0,
               8'hFF, 8'h00, 2'd3};
    tbl[4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'd2, 8'h5A, 1'b1, 1'b0, 1'b0, 1,
               64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0, 64'h0, 8'h5A, 8'h00, 2'd2};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2'd3, 8'hFF, 1'b1, 1'b1, 1'b1, 1,
               64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'd0};
    tbl[6] = '{64'hAA, 64'h55, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1,
               64'hAA, 64'h55, 64'h0, 64'h0, 8'h01, 8'h00, 2'd0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    tag = "reset";
    chk("valid", out_valid, 0);
    chk("in_ready", in_ready, 1);
    chk("turn", out_turn, 0);
    chk("last", out_last, 0);
    chk("err", err_sew, 0);
    chk("vec0", out_vec0, 0);
    chk("vec1", out_vec1, 0);
    chk("be", out_be, 0);
    chk("sew", out_sew, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    tag = "stall";
    out_ready = 1'b0;
    drive(tbl[3]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("valid", out_valid, 1);
      chk("vec0", out_vec0, tbl[3].a0);
      chk("be", out_be, 8'hFF);
      chk("turn", out_turn, 0);
      chk("last", out_last, SKIP);
      chk("in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("vec0_hold", out_vec0, tbl[3].a0);
    @(negedge clk);
`ifdef VWIDEN_SEQ_HALF_SKIP_EN
    chk("skip_idle", out_valid, 0);
`else
    chk("b1_valid", out_valid, 1);
    chk("b1_vec0", out_vec0, tbl[3].b0);
    chk("b1_be", out_be, 8'h00);
    chk("b1_turn", out_turn, 1);
    chk("b1_last", out_last, 1);
    @(negedge clk);
    chk("idle", out_valid, 0);
`endif

    tag = "b2b";
    in_vec0 = 64'hA1; in_vec1 = '0; in_sew = 2'd0; in_be = 8'hFF; in_widen = 1'b0;
    in_signed0 = 1'b0; in_signed1 = 1'b0; in_valid = 1'b1;
    chk("rdy0", in_ready, 1);
    @(negedge clk);
    chk("p1_valid", out_valid, 1);
    chk("p1_vec0", out_vec0, 64'hA1);
    chk("p1_last", out_last, 1);
    chk("p1_rdy", in_ready, 1);
    in_vec0 = 64'h1122_3344_5566_7788; in_widen = 1'b1;
    @(negedge clk);
    chk("w0_valid", out_valid, 1);
    chk("w0_vec0", out_vec0, 64'h0055_0066_0077_0088);
    chk("w0_last", out_last, 0);
    chk("w0_rdy", in_ready, 0);
    in_vec0 = 64'hB2; in_widen = 1'b0;
    @(negedge clk);
    chk("w1_valid", out_valid, 1);
    chk("w1_vec0", out_vec0, 64'h0011_0022_0033_0044);
    chk("w1_turn", out_turn, 1);
    chk("w1_last", out_last, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("p2_valid", out_valid, 1);
    chk("p2_vec0", out_vec0, 64'hB2);
    chk("p2_sew", out_sew, 0);
    @(negedge clk);
    chk("idle", out_valid, 0);

    tag = "sew3";
    out_ready = 1'b0;
    drive(tbl[5]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("valid", out_valid, 1);
    chk("err", err_sew, 1);
    chk("be", out_be, 0);
    chk("last", out_last, 1);
    @(negedge clk);
    chk("valid2", out_valid, 1);
    chk("err2", err_sew, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("done", out_valid, 0);
    chk("err3", err_sew, 0);

    tag = "rst_mid";
    out_ready = 1'b0;
    drive(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("valid_after", out_valid, 0);
    chk("rdy_after", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      chk("no_beat1", out_valid, 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vwiden_seq.md
# vwiden_seq

Two-beat sequencer for the vector ALU's widening path. It accepts one SEW-wide operand pair per valid/ready handshake and holds it in a capture register. It then drives the combinational widening datapath twice, low half then high half, so one source beat becomes two 2*SEW result beats for the downstream ALU lane. Non-widening requests pass through in a single beat with SEW unchanged.

## Interface
- `DATA_WIDTH`, 64, operand/result width in bits.
- `SEW_WIDTH`, 2, element-width code width (0=8b, 1=16b, 2=32b, 3=64b).
- `BE_WIDTH`, `DATA_WIDTH/8`, byte-enable width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  sequencer can capture a request this cycle.
- `in_vec0`, `in_vec1`  in  DATA_WIDTH  source operands.
- `in_sew`  in  SEW_WIDTH  source element width.
- `in_be`  in  BE_WIDTH  source byte enables.
- `in_signed0`, `in_signed1`  in  1  per-operand sign extension.
- `in_widen`  in  1  1 = widening op (two beats); 0 = pass-through (one beat).
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_vec0`, `out_vec1`  out  DATA_WIDTH  result operands.
- `out_be`  out  BE_WIDTH  result byte enables.
- `out_sew`  out  SEW_WIDTH  result element width.
- `out_turn`  out  1  0 = low-half beat, 1 = high-half beat.
- `out_last`  out  1  final beat of the current request.
- `err_sew`  out  1  one-cycle pulse: widening requested with `in_sew`=3.

## Operation
- States:
  - IDLE: nothing held.
  - BEAT0: low half (or pass-through) presented.
  - BEAT1: high half presented.
- Capture register holds vec0/vec1/sew/be/signed0/signed1/widen. It loads on `in_valid && in_ready`.
- Transitions:
  - IDLE + accept → BEAT0.
  - BEAT0 + `out_ready`:
    - → BEAT1 if widen and sew<3.
    - else → BEAT0 if a new request is accepted in the same cycle.
    - else → IDLE.
  - BEAT1 + `out_ready` → BEAT0 if a new request is accepted in the same cycle, else → IDLE.
  - Any state without `out_ready` holds.
- `in_ready` = (state==IDLE) || (`out_valid && out_ready && out_last`). This allows back-to-back requests with no bubble.
- Widening beat, turn t:
  - Each element of source half t (bits `t*DATA_WIDTH/2 +: DATA_WIDTH/2`) is zero- or sign-extended to 2*SEW per operand.
  - `out_be` is each source-half byte enable duplicated ×2.
  - `out_sew` = captured sew + 1.
- Pass-through beat: `out_vec*`, `out_be`, `out_sew` equal the captured values; `out_turn`=0; `out_last`=1.
- Illegal widen (sew=3): one beat with `out_vec*`=0, `out_be`=0, `out_sew`=0, `out_last`=1. `err_sew`=1 in that beat's first valid cycle only.
- Outputs change only on an `out_valid && out_ready` transfer or on capture. They are stable while stalled.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1 (state IDLE), `out_turn`=0, `out_last`=0, `err_sew`=0, all data/be/sew outputs 0.
- Latency: request captured at edge N; first beat valid in cycle N+1.
- Throughput with `out_ready` held high:
  - widening: 1 request per 2 cycles;
  - pass-through: 1 request per cycle.
- Simultaneous final-beat transfer and new capture: the new request's first beat is valid the next cycle, with no idle cycle.
- `rst` mid-request: the held request is discarded. State goes to IDLE and `out_valid`=0 the cycle after reset is sampled. No partial second beat is ever emitted.
- `in_valid` while `in_ready`=0 is ignored; upstream must hold it.

## Configuration
- `VWIDEN_SEQ_HALF_SKIP_EN` defined:
  - For a widening request whose upper-half byte enables are all zero, BEAT0 is marked `out_last`=1 and BEAT1 is skipped.
  - The request completes in one beat.
- Undefined: every legal widening request always produces two beats, including BEAT1 with `out_be`=0.

## Test plan
- Widen, sew=0, unsigned:
  - stimulus: `in_vec0`=0x8081_8283_8485_8687, `in_be`=0xFF, `out_ready`=1.
  - required: beat0 `out_vec0`=0x0084_0085_0086_0087; beat1 `out_vec0`=0x0080_0081_0082_0083; `out_sew`=1; `out_be`=0xFF both beats; `out_last` only on beat1.
- Same request with `in_signed0`=1:
  - required: beat0 `out_vec0`=0xFF84_FF85_FF86_FF87.
- Widen, sew=2, `in_be`=0x0F, with `out_ready` low for 3 cycles during BEAT0:
  - required: outputs stable through the stall; beat1 `out_be`=0x00 (two beats without the macro, one beat with it).
- Back-to-back:
  - stimulus: pass-through, widen, pass-through, with `in_valid` and `out_ready` continuously high.
  - required: 4 beats in 4 consecutive cycles with no bubbles.
- Widen with sew=3:
  - required: single beat with `out_be`=0, `err_sew` pulses for exactly one cycle.
- `rst` asserted during BEAT0 of a widen:
  - required: next cycle `out_valid`=0 and `in_ready`=1; no beat1 ever appears.
